// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the IF/MEM unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 2;
  localparam int DEF_TIMEOUT    = 64;
  localparam int STARVE_W       = 2;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Clearable up-counter; tc flags the enabled cycle that brings the count to LIMIT.
module arb_wait_counter #(
  parameter int LIMIT = 64,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = en & ~clr & (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory between instruction fetch and the load/store stage.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  arb_state_t          state_reg, state_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic                cancel_reg, cancel_next;
  logic                mem_wr_reg, mem_wr_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                grant_d, grant_i, in_acc, dm_any, force_if, timeout_hit;

  assign dm_any   = dm_rd | dm_wr;
  assign in_acc   = (state_reg == D_ACC) | (state_reg == I_ACC);
  assign force_if = if_req & (starve_reg == STARVE_W'(STARVE_MAX));

  arb_wait_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (grant_d | grant_i),
    .en  (in_acc & ~mem_done),
    .tc  (timeout_hit)
  );

  // On completion only the other requester is considered, giving zero-gap D<->I handoff.
  always_comb begin
    state_next = state_reg;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_done || (dm_rd && dm_wr)) state_next = ERR;
        else if (dm_any && !force_if)     grant_d = 1'b1;
        else if (if_req)                  grant_i = 1'b1;
      end
      D_ACC: begin
        if (mem_done) begin
          if (if_req) grant_i = 1'b1;
          else        state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      I_ACC: begin
        if (mem_done) begin
          if (dm_any) grant_d = 1'b1;
          else        state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      ERR: state_next = ERR;
    endcase
    if (grant_d) state_next = D_ACC;
    if (grant_i) state_next = I_ACC;
  end

  always_comb begin
    starve_next    = starve_reg;
    mem_wr_next    = mem_wr_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if (grant_i) begin
      starve_next   = '0;
      mem_wr_next   = 1'b0;
      mem_addr_next = if_addr;
    end
    if (grant_d) begin
      mem_wr_next    = dm_wr;
      mem_addr_next  = dm_addr;
      mem_wdata_next = dm_wdata;
      // The fetch being handed off from I_ACC was just served, so it is not starving.
      if ((state_reg == IDLE) && if_req && !force_if) starve_next = starve_reg + 2'd1;
    end
    cancel_next = (state_reg == I_ACC) && (state_next == I_ACC) && (cancel_reg || if_cancel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      cancel_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      cancel_reg    <= cancel_next;
      mem_wr_reg    <= mem_wr_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign mem_req   = in_acc;
  assign mem_wr    = mem_wr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign err       = (state_reg == ERR);
  assign dm_done   = (state_reg == D_ACC) & mem_done;
  assign dm_stall  = dm_any & ~dm_done;
  assign dm_rdata  = dm_done ? mem_rdata : '0;
  assign if_valid  = (state_reg == I_ACC) & mem_done & ~cancel_reg & ~if_cancel;
  assign if_stall  = if_req & ~if_valid;
  assign if_rdata  = if_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 2;
  localparam int TIMEOUT    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req, if_cancel, dm_rd, dm_wr, mem_done;
  logic [ADDR_W-1:0] if_addr, dm_addr;
  logic [DATA_W-1:0] dm_wdata, mem_rdata;
  logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              if_valid, if_stall, dm_done, dm_stall, mem_req, mem_wr, err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; if_cancel = 0; dm_rd = 0; dm_wr = 0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_done = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_wr, err, if_valid, if_stall, dm_done, dm_stall} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {mem_req, mem_wr, err, if_valid, if_stall, dm_done, dm_stall});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    $display("test_reset done");
  endtask

  task automatic test_fetch_only();
    apply_reset();
    if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++; $display("FAIL fetch_idle: got req=%b stall=%b expected req=0 stall=1", mem_req, if_stall);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      mem_done = (c == 4); mem_rdata = 16'hC0DE;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
        n_fail++; $display("FAIL fetch_bus c%0d: got req=%b addr=%h wr=%b expected 1/0010/0", c, mem_req, mem_addr, mem_wr);
      end
      n_cmp++;
      if (if_valid !== (c == 4) || if_stall !== (c != 4)) begin
        n_fail++; $display("FAIL fetch_valid c%0d: got valid=%b stall=%b", c, if_valid, if_stall);
      end
    end
    n_cmp++;
    if (if_rdata !== 16'hC0DE) begin
      n_fail++; $display("FAIL fetch_rdata: got %h expected c0de", if_rdata);
    end
    $display("txn fetch addr=0010 rdata=%h", if_rdata);
    next_cycle();
    if_req = 0; mem_done = 0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_after: got req=%b valid=%b expected 0/0", mem_req, if_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    dm_rd = 1; dm_addr = 16'h0200; if_req = 1; if_addr = 16'h0040;
    @(negedge clk);
    n_cmp++;
    if (dm_stall !== 1'b1 || if_stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got dstall=%b istall=%b req=%b expected 1/1/0", dm_stall, if_stall, mem_req);
    end
    next_cycle();
    mem_done = 1; mem_rdata = 16'h1234;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || dm_done !== 1'b1 || dm_rdata !== 16'h1234 || dm_stall !== 1'b0) begin
      n_fail++; $display("FAIL b2b_data: got req=%b addr=%h done=%b rdata=%h dstall=%b expected 1/0200/1/1234/0",
                         mem_req, mem_addr, dm_done, dm_rdata, dm_stall);
    end
    $display("txn load addr=0200 rdata=%h", dm_rdata);
    next_cycle();
    dm_rd = 0; mem_rdata = 16'h5678;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || if_valid !== 1'b1 || if_rdata !== 16'h5678) begin
      n_fail++; $display("FAIL b2b_fetch: got req=%b addr=%h valid=%b rdata=%h expected 1/0040/1/5678",
                         mem_req, mem_addr, if_valid, if_rdata);
    end
    $display("txn fetch addr=0040 rdata=%h", if_rdata);
    next_cycle();
    if_req = 0; mem_done = 0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    if_addr = 16'h0080; dm_addr = 16'h0300;
    // Two data grants taken while fetch is waiting; fetch request drops (flush) before each completes.
    for (int g = 0; g < 2; g++) begin
      dm_rd = 1; if_req = 1; mem_done = 0;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0) begin
        n_fail++; $display("FAIL starve_idle%0d: got req=%b expected 0", g, mem_req);
      end
      next_cycle();
      if_req = 0; mem_done = 1;
      @(negedge clk);
      n_cmp++;
      if (mem_addr !== 16'h0300 || dm_done !== 1'b1) begin
        n_fail++; $display("FAIL starve_data%0d: got addr=%h done=%b expected 0300/1", g, mem_addr, dm_done);
      end
      next_cycle();
    end
    dm_rd = 1; if_req = 1; mem_done = 0;
    next_cycle();
    mem_done = 1; mem_rdata = 16'h7777;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0080 || if_valid !== 1'b1 || dm_stall !== 1'b1) begin
      n_fail++; $display("FAIL starve_force: got req=%b addr=%h valid=%b dstall=%b expected 1/0080/1/1",
                         mem_req, mem_addr, if_valid, dm_stall);
    end
    $display("txn forced fetch addr=0080 rdata=%h", if_rdata);
    next_cycle();
    if_req = 0;
    @(negedge clk);
    n_cmp++;
    if (mem_addr !== 16'h0300 || dm_done !== 1'b1) begin
      n_fail++; $display("FAIL starve_handoff: got addr=%h done=%b expected 0300/1", mem_addr, dm_done);
    end
    // Counter cleared by the fetch grant: data wins again even with fetch waiting.
    next_cycle();
    mem_done = 0; if_req = 1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0300) begin
      n_fail++; $display("FAIL starve_cleared: got req=%b addr=%h expected 1/0300", mem_req, mem_addr);
    end
  endtask

  task automatic test_cancel();
    apply_reset();
    if_req = 1; if_addr = 16'h0100;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if_cancel = (c == 1); mem_done = (c == 3); mem_rdata = 16'h1111;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1 || if_valid !== 1'b0 || if_stall !== 1'b1) begin
        n_fail++; $display("FAIL cancel_c%0d: got req=%b valid=%b stall=%b expected 1/0/1", c, mem_req, if_valid, if_stall);
      end
    end
    $display("txn cancelled fetch addr=0100");
    next_cycle();
    mem_done = 0; if_cancel = 1;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++; $display("FAIL cancel_idle: got req=%b stall=%b expected 0/1", mem_req, if_stall);
    end
    next_cycle();
    if_cancel = 0; mem_done = 1; mem_rdata = 16'h2222;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || if_valid !== 1'b1 || if_rdata !== 16'h2222) begin
      n_fail++; $display("FAIL cancel_refetch: got req=%b valid=%b rdata=%h expected 1/1/2222", mem_req, if_valid, if_rdata);
    end
    $display("txn fetch addr=0100 rdata=%h", if_rdata);
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit ended = 0;
    apply_reset();
    dm_wr = 1; dm_addr = 16'h0500; dm_wdata = 16'hA5A5;
    for (int c = 0; c < 200 && !ended; c++) begin
      next_cycle();
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (cnt == 0) begin
          n_cmp++;
          if (mem_wr !== 1'b1 || mem_wdata !== 16'hA5A5 || mem_addr !== 16'h0500 || err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_bus: got wr=%b wdata=%h addr=%h err=%b expected 1/a5a5/0500/0",
                               mem_wr, mem_wdata, mem_addr, err);
          end
        end
        cnt++;
      end else begin
        ended = 1;
      end
    end
    n_cmp++;
    if (!ended || cnt != TIMEOUT || err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_len: got ended=%0d cycles=%0d err=%b expected 1/%0d/1", ended, cnt, err, TIMEOUT);
    end
    $display("txn store timed out after %0d cycles", cnt);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b1 || mem_req !== 1'b0 || dm_stall !== 1'b1) begin
        n_fail++; $display("FAIL timeout_hold%0d: got err=%b req=%b dstall=%b expected 1/0/1", c, err, mem_req, dm_stall);
      end
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got err=%b expected 0", err);
    end
  endtask

  task automatic test_protocol();
    apply_reset();
    dm_rd = 1; dm_wr = 1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b1 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL proto_rdwr%0d: got err=%b req=%b expected 1/0", c, err, mem_req);
      end
    end
    apply_reset();
    mem_done = 1;
    next_cycle();
    mem_done = 0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL proto_stray_done: got err=%b expected 1", err);
    end
    apply_reset();
    dm_rd = 1; dm_addr = 16'h0400;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL proto_pre_rst: got req=%b expected 1", mem_req);
    end
    #2;
    rst = 1;
    clear_inputs();
    #1;
    n_cmp++;
    if ({mem_req, mem_wr, err, if_valid, if_stall, dm_done, dm_stall, mem_addr} !== 23'h0) begin
      n_fail++; $display("FAIL proto_async_rst: got %h expected 0",
                         {mem_req, mem_wr, err, if_valid, if_stall, dm_done, dm_stall, mem_addr});
    end
    next_cycle();
    rst = 0;
  endtask

  // Reference model: who owns the memory, plus the starvation, elapsed-cycle and cancel bookkeeping.
  task automatic test_random();
    int owner = 0;          // 0 free, 1 data, 2 fetch, 3 error
    int starve = 0;
    int waited = 0;
    bit canc = 0;
    bit wr = 0;
    logic [15:0] a = '0;
    logic [15:0] w = '0;
    bit gd, gi, busy, e_dd, e_iv;
    int n_owner;
    logic [5:0] e_ctrl;
    logic [15:0] e_ird, e_drd;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if (c > 0) next_cycle();
      busy = (owner == 1 || owner == 2);
      if_req = if_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: begin dm_rd = 0; dm_wr = 0; end
          1: begin dm_rd = 1; dm_wr = 0; end
          default: begin dm_rd = 0; dm_wr = 1; end
        endcase
        dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) if_addr = 16'($urandom);
      if_cancel = ($urandom_range(0, 9) == 0);
      mem_done = busy && ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      e_dd  = (owner == 1) && mem_done;
      e_iv  = (owner == 2) && mem_done && !canc && !if_cancel;
      e_ctrl = {busy, e_dd, e_iv, if_req && !e_iv, (dm_rd || dm_wr) && !e_dd, owner == 3};
      e_ird = e_iv ? mem_rdata : 16'h0;
      e_drd = e_dd ? mem_rdata : 16'h0;
      n_cmp++;
      if ({mem_req, dm_done, if_valid, if_stall, dm_stall, err} !== e_ctrl) begin
        n_fail++; $display("FAIL rand_ctrl cyc%0d: got %b expected %b (req,dd,iv,is,ds,err)",
                           c, {mem_req, dm_done, if_valid, if_stall, dm_stall, err}, e_ctrl);
      end
      n_cmp++;
      if (if_rdata !== e_ird || dm_rdata !== e_drd) begin
        n_fail++; $display("FAIL rand_rdata cyc%0d: got if=%h dm=%h expected if=%h dm=%h", c, if_rdata, dm_rdata, e_ird, e_drd);
      end
      if (busy) begin
        n_cmp++;
        if (mem_addr !== a || mem_wr !== wr || (wr && mem_wdata !== w)) begin
          n_fail++; $display("FAIL rand_bus cyc%0d: got addr=%h wr=%b wdata=%h expected addr=%h wr=%b wdata=%h",
                             c, mem_addr, mem_wr, mem_wdata, a, wr, w);
        end
      end
      if (busy && mem_done)
        $display("txn cyc%0d %s addr=%h rdata=%h%s", c, (owner == 1) ? (wr ? "store" : "load ") : "fetch",
                 a, mem_rdata, (owner == 2 && !e_iv) ? " cancelled" : "");
      n_owner = owner; gd = 0; gi = 0;
      case (owner)
        0: begin
          if (mem_done || (dm_rd && dm_wr)) n_owner = 3;
          else if ((dm_rd || dm_wr) && !(if_req && starve == STARVE_MAX)) gd = 1;
          else if (if_req) gi = 1;
        end
        1: begin
          if (mem_done) begin if (if_req) gi = 1; else n_owner = 0; end
          else if (waited + 1 == TIMEOUT) n_owner = 3;
        end
        2: begin
          if (mem_done) begin if (dm_rd || dm_wr) gd = 1; else n_owner = 0; end
          else if (waited + 1 == TIMEOUT) n_owner = 3;
        end
        default: ;
      endcase
      if (gd || gi) waited = 0;
      else if (busy && !mem_done) waited++;
      canc = (owner == 2 && !mem_done && n_owner == 2) ? (canc || if_cancel) : 1'b0;
      if (gi) begin
        starve = 0; a = if_addr; wr = 0; n_owner = 2;
      end
      if (gd) begin
        if (owner == 0 && if_req && starve < STARVE_MAX) starve++;
        a = dm_addr; w = dm_wdata; wr = dm_wr; n_owner = 1;
      end
      owner = n_owner;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_only();
    test_back_to_back();
    test_starvation();
    test_cancel();
    test_timeout();
    test_protocol();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
